ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester round-robin arbiter that shares one `ram_single_port_sync` instance between port A (instruction fetch) and port B (load/store). It registers the request fields, sequences each access through the RAM's one-cycle synchronous read, returns read data, and pulses a per-port acknowledge. It sits between the core's fetch and LSU front-ends and the RAM's enable/rw/address/data_in/data_out pins.

## Interface

Parameters:
- ADDRESS_WIDTH, 16, RAM address width
- DATA_WIDTH, 16, RAM data width

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_a  in  1  port A request; level, held until ack_a
- rw_a  in  1  port A direction: 0 = read, 1 = write
- address_a  in  ADDRESS_WIDTH  port A address
- data_in_a  in  DATA_WIDTH  port A write data
- ack_a  out  1  one-cycle completion pulse for port A
- data_out_a  out  DATA_WIDTH  port A read data; valid while ack_a=1, held until the next port A read completes
- req_b, rw_b, address_b, data_in_b, ack_b, data_out_b: identical meaning for port B
- busy  out  1  high in every state except IDLE
- mem_enable  out  1  to RAM enable
- mem_rw  out  1  to RAM rw
- mem_address  out  ADDRESS_WIDTH  to RAM address
- mem_data_in  out  DATA_WIDTH  to RAM data_in
- mem_data_out  in  DATA_WIDTH  from RAM data_out

## Operation

- FSM states: IDLE, ISSUE, CAPTURE, DONE. Transitions: IDLE→ISSUE when any req is high; ISSUE→CAPTURE, CAPTURE→DONE and DONE→IDLE are unconditional.
- Arbitration happens only in IDLE:
  - Only one req high: that port is granted.
  - Both high: the port not granted last is granted, and last_grant updates on every grant.
  - last_grant resets so port A wins the first contention.
- On grant (IDLE→ISSUE edge):
  - Granted port's rw/address/data_in are registered into mem_rw, mem_address and mem_data_in.
  - mem_enable is set to 1.
  - The grant id is held in a register.
- ISSUE: mem_enable=1, so the RAM performs the read or write at the end of this cycle. mem_enable clears on the ISSUE→CAPTURE edge.
- CAPTURE: mem_enable=0. If the access is a read, data_out_x of the granted port loads mem_data_out at the end of this cycle. A write leaves data_out_x unchanged.
- DONE: ack of the granted port is 1 for exactly this cycle, and the other ack is 0. req inputs are ignored in DONE, so a requester still holding req during its ack cycle is not re-granted.
- Requester rule: fields must be stable from req rise until ack. After ack, req must be low, or carry a new request, by the following cycle.
- The ungranted requester waits with req held; it is not lost.
- Requests are never reordered within a port, and at most one access is in flight.

## Timing

- Reset (reset_n=0, asynchronous), all forced immediately:
  - State goes to IDLE and last_grant to "B", so A wins first.
  - mem_enable, mem_rw, mem_address, mem_data_in, ack_a, ack_b, busy, data_out_a and data_out_b all go to 0.
- Reset mid-access: the in-flight access is dropped with no ack. Because mem_enable drops asynchronously, a write in ISSUE does not commit at the next edge.
- Latency for a request seen in IDLE at cycle 0:
  - cycle 1: ISSUE (mem_enable=1)
  - cycle 2: CAPTURE
  - cycle 3: DONE (ack=1, read data valid)
  - cycle 4: IDLE
- Request-to-ack is 3 cycles, and occupancy is 4 cycles per access.
- Back-to-back: a new or waiting request is sampled in cycle 4, giving a peak rate of one access per 4 cycles.
- Contention with both ports requesting continuously: grants alternate A, B, A, B, so each port completes one access per 8 cycles.
- Reads and writes have identical timing.
- All outputs are registered; nothing combinational runs from req to the mem_* outputs.

## Test plan

- Reset: hold reset_n=0 mid-ISSUE of a write of 0xBEEF to 0x0005 → mem_enable drops immediately. After release, reading 0x0005 returns its old value, and all outputs were 0 during reset.
- Single read: RAM[0x0010]=0x1234, req_a read at cycle 0 → mem_enable high only in cycle 1 with mem_address=0x0010. ack_a is high in cycle 3 with data_out_a=0x1234, and ack_b stays 0.
- Write then read: port B writes 0xA5A5 to 0x0003 → ack_b in cycle 3 with data_out_b unchanged. A port B read of 0x0003 issued in cycle 4 returns 0xA5A5 with ack_b in cycle 7.
- Contention: req_a and req_b both raised in cycle 0 after reset and held → grants go A then B then A, with ack_a in cycles 3 and 11 and ack_b in cycle 7.
- Held req during ack: req_a kept high through DONE and dropped at cycle 4 → exactly one access and one ack_a.
- Data hold: port A reads 0x7777 and then port B performs a write → data_out_a stays 0x7777 through port B's transaction.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter that shares one single-port synchronous
// RAM between an instruction-fetch port (A) and a load/store port (B).
// Each access runs IDLE -> ISSUE -> CAPTURE -> DONE. All outputs are registered.
module ram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,

    // Port A (instruction fetch)
    input  logic                     req_a,
    input  logic                     rw_a,
    input  logic [ADDRESS_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0]    data_in_a,
    output logic                     ack_a,
    output logic [DATA_WIDTH-1:0]    data_out_a,

    // Port B (load/store)
    input  logic                     req_b,
    input  logic                     rw_b,
    input  logic [ADDRESS_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0]    data_in_b,
    output logic                     ack_b,
    output logic [DATA_WIDTH-1:0]    data_out_b,

    // Status
    output logic                     busy,

    // RAM side
    output logic                     mem_enable,
    output logic                     mem_rw,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // FSM and arbitration state
    state_t                   state_q,      state_d;
    port_t                    last_grant_q, last_grant_d;
    port_t                    grant_q,      grant_d;

    // Registered RAM command
    logic                     mem_enable_q,  mem_enable_d;
    logic                     mem_rw_q,      mem_rw_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]    mem_data_in_q, mem_data_in_d;

    // Registered requester-side outputs
    logic                     ack_a_q,      ack_a_d;
    logic                     ack_b_q,      ack_b_d;
    logic                     busy_q,       busy_d;
    logic [DATA_WIDTH-1:0]    data_out_a_q, data_out_a_d;
    logic [DATA_WIDTH-1:0]    data_out_b_q, data_out_b_d;

    // Arbitration result, only consumed in IDLE
    port_t                    pick;

    // Round-robin choice: a lone requester wins; on contention the port not granted last wins.
    always_comb begin
        pick = PORT_A;
        if (req_a && req_b) begin
            pick = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            pick = PORT_B;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        mem_enable_d  = 1'b0;
        mem_rw_d      = mem_rw_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        data_out_a_d  = data_out_a_q;
        data_out_b_d  = data_out_b_q;

        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    state_d      = ST_ISSUE;
                    grant_d      = pick;
                    last_grant_d = pick;
                    mem_enable_d = 1'b1;
                    if (pick == PORT_A) begin
                        mem_rw_d      = rw_a;
                        mem_address_d = address_a;
                        mem_data_in_d = data_in_a;
                    end else begin
                        mem_rw_d      = rw_b;
                        mem_address_d = address_b;
                        mem_data_in_d = data_in_b;
                    end
                end
            end

            // The RAM performs the access at the end of this cycle.
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end

            // Read data is on mem_data_out now; writes leave data_out untouched.
            ST_CAPTURE: begin
                state_d = ST_DONE;
                if (!mem_rw_q) begin
                    if (grant_q == PORT_A) begin
                        data_out_a_d = mem_data_out;
                    end else begin
                        data_out_b_d = mem_data_out;
                    end
                end
            end

            // Requests are ignored here so a req still held during ack is not re-granted.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ack_a_d = (state_d == ST_DONE) && (grant_d == PORT_A);
        ack_b_d = (state_d == ST_DONE) && (grant_d == PORT_B);
        busy_d  = (state_d != ST_IDLE);
    end

    // State register; reset also drops mem_enable at once so an ISSUE-cycle write never commits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= PORT_B;
            grant_q       <= PORT_A;
            mem_enable_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            busy_q        <= 1'b0;
            data_out_a_q  <= '0;
            data_out_b_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its _d, independent of statement order.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            mem_enable_q  <= mem_enable_d;
            mem_rw_q      <= mem_rw_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            busy_q        <= busy_d;
            data_out_a_q  <= data_out_a_d;
            data_out_b_q  <= data_out_b_d;
        end
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign busy        = busy_q;
    assign data_out_a  = data_out_a_q;
    assign data_out_b  = data_out_b_q;
    assign mem_enable  = mem_enable_q;
    assign mem_rw      = mem_rw_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized two-port traffic.
// Expected responses are queued per port when a request is raised; a monitor
// pops them on each ack and also tracks what data_out must hold between acks.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_a, rw_a, req_b, rw_b;
    logic [15:0] address_a, data_in_a, address_b, data_in_b;
    logic        ack_a, ack_b, busy;
    logic [15:0] data_out_a, data_out_b;
    logic        mem_enable, mem_rw;
    logic [15:0] mem_address, mem_data_in, mem_data_out;

    int          checks;
    int          errors;
    int          cyc;
    int          ack_cnt_a, ack_cnt_b, en_cnt;
    logic [15:0] held_a, held_b;
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    bit          grant_log[$];
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] ram [0:65535];

    ram_port_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .req_a       (req_a),
        .rw_a        (rw_a),
        .address_a   (address_a),
        .data_in_a   (data_in_a),
        .ack_a       (ack_a),
        .data_out_a  (data_out_a),
        .req_b       (req_b),
        .rw_b        (rw_b),
        .address_b   (address_b),
        .data_in_b   (data_in_b),
        .ack_b       (ack_b),
        .data_out_b  (data_out_b),
        .busy        (busy),
        .mem_enable  (mem_enable),
        .mem_rw      (mem_rw),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port synchronous RAM.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_rw) ram[mem_address] <= mem_data_in;
            else        mem_data_out     <= ram[mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"},     32'({ack_a, ack_b, busy, mem_enable, mem_rw}), 'h0);
        check({tag, "_mem_addr"}, 32'(mem_address), 'h0);
        check({tag, "_mem_din"},  32'(mem_data_in), 'h0);
        check({tag, "_dout_a"},   32'(data_out_a), 'h0);
        check({tag, "_dout_b"},   32'(data_out_b), 'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        sync();
    endtask

    // Issue one port A access starting in the current cycle; returns req-to-ack latency.
    task automatic access_a(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                            output int lat);
        exp_t e;
        int   t0;
        bit   got;
        rw_a = rw; address_a = addr; data_in_a = data; req_a = 1'b1;
        if (rw) model_mem[addr] = data;
        e.is_read = !rw;
        e.data    = rw ? 16'h0 : model_mem[addr];
        exp_a.push_back(e);
        t0 = cyc; got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (ack_a) got = 1'b1;
        end
        lat = got ? cyc - t0 : -1;
        if (!got) check("ack_a_timeout", 'h0, 'h1);
        sync();
        req_a = 1'b0;
    endtask

    task automatic access_b(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                            output int lat);
        exp_t e;
        int   t0;
        bit   got;
        rw_b = rw; address_b = addr; data_in_b = data; req_b = 1'b1;
        if (rw) model_mem[addr] = data;
        e.is_read = !rw;
        e.data    = rw ? 16'h0 : model_mem[addr];
        exp_b.push_back(e);
        t0 = cyc; got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (ack_b) got = 1'b1;
        end
        lat = got ? cyc - t0 : -1;
        if (!got) check("ack_b_timeout", 'h0, 'h1);
        sync();
        req_b = 1'b0;
    endtask

    // Samples five consecutive cycles starting with the current one.
    task automatic watch5(output logic [4:0] en, output logic [4:0] aa, output logic [4:0] ab,
                          output logic [4:0] bz, output logic [15:0] addr1);
        en = '0; aa = '0; ab = '0; bz = '0; addr1 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            en[k] = mem_enable; aa[k] = ack_a; ab[k] = ack_b; bz[k] = busy;
            if (k == 1) addr1 = mem_address;
        end
    endtask

    // Scoreboard monitor: pops expectations on ack and checks held read data every cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_a = '0;
                held_b = '0;
            end else begin
                if (mem_enable) en_cnt++;
                if (ack_a && ack_b) check("ack_both", 'h1, 'h0);
                if (ack_a) begin
                    ack_cnt_a++;
                    grant_log.push_back(1'b0);
                    if (exp_a.size() == 0) check("ack_a_unexpected", 'h1, 'h0);
                    else begin
                        e = exp_a.pop_front();
                        if (e.is_read) held_a = e.data;
                    end
                end
                if (ack_b) begin
                    ack_cnt_b++;
                    grant_log.push_back(1'b1);
                    if (exp_b.size() == 0) check("ack_b_unexpected", 'h1, 'h0);
                    else begin
                        e = exp_b.pop_front();
                        if (e.is_read) held_b = e.data;
                    end
                end
                check("data_out_a", 32'(data_out_a), 32'(held_a));
                check("data_out_b", 32'(data_out_b), 32'(held_b));
            end
        end
    endtask

    initial begin
        int          lat, la1, la2, lb;
        int          n0, e0;
        logic [4:0]  en_p, aa_p, ab_p, bz_p;
        logic [15:0] addr1;

        checks = 0; errors = 0; cyc = 0;
        ack_cnt_a = 0; ack_cnt_b = 0; en_cnt = 0;
        held_a = '0; held_b = '0;
        rst_n = 1'b0;
        req_a = 1'b0; rw_a = 1'b0; address_a = '0; data_in_a = '0;
        req_b = 1'b0; rw_b = 1'b0; address_b = '0; data_in_b = '0;
        fork
            monitor();
        join_none

        // Reset state
        #1 check_outputs_zero("por");
        #20 rst_n = 1'b1;
        sync();

        // Reset during the ISSUE cycle of a write must drop it
        access_a(1'b1, 16'h0005, 16'h1111, lat);
        check("setup_lat", 32'(lat), 'd3);
        rw_b = 1'b1; address_b = 16'h0005; data_in_b = 16'hBEEF; req_b = 1'b1;
        @(posedge clk);
        #1 check("issue_enable", 32'(mem_enable), 'h1);
        check("issue_addr", 32'(mem_address), 'h5);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_rst");
        req_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        sync();
        access_a(1'b0, 16'h0005, 16'h0000, lat);
        check("post_rst_read_lat", 32'(lat), 'd3);
        check("post_rst_read_data", 32'(data_out_a), 'h1111);

        // Single read: enable only in cycle 1, ack_a only in cycle 3
        access_a(1'b1, 16'h0010, 16'h1234, lat);
        fork
            access_a(1'b0, 16'h0010, 16'h0000, lat);
            watch5(en_p, aa_p, ab_p, bz_p, addr1);
        join
        check("read_lat", 32'(lat), 'd3);
        check("read_enable_pattern", 32'(en_p), 'b00010);
        check("read_ack_a_pattern", 32'(aa_p), 'b01000);
        check("read_ack_b_pattern", 32'(ab_p), 'b00000);
        check("read_busy_pattern", 32'(bz_p), 'b01110);
        check("read_mem_address", 32'(addr1), 'h0010);
        check("read_data", 32'(data_out_a), 'h1234);

        // Write then back-to-back read on port B
        sync();
        access_b(1'b1, 16'h0003, 16'hA5A5, lat);
        check("b_write_lat", 32'(lat), 'd3);
        check("b_write_dout_kept", 32'(data_out_b), 'h0);
        access_b(1'b0, 16'h0003, 16'h0000, lat);
        check("b_read_lat", 32'(lat), 'd3);
        check("b_read_data", 32'(data_out_b), 'hA5A5);

        // Contention from reset: A, B, A with acks at cycles 3, 7, 11
        do_reset();
        grant_log.delete();
        fork
            begin
                access_a(1'b0, 16'h0010, 16'h0000, la1);
                access_a(1'b0, 16'h0005, 16'h0000, la2);
            end
            access_b(1'b0, 16'h0003, 16'h0000, lb);
        join
        check("cont_a1_lat", 32'(la1), 'd3);
        check("cont_b_lat", 32'(lb), 'd7);
        check("cont_a2_lat", 32'(la2), 'd7);
        check("cont_grants", 32'(grant_log.size()), 'd3);
        if (grant_log.size() == 3)
            check("cont_order", 32'({grant_log[0], grant_log[1], grant_log[2]}), 'b010);

        // Req held through DONE yields exactly one access
        idle(2);
        n0 = ack_cnt_a; e0 = en_cnt;
        access_a(1'b0, 16'h0003, 16'h0000, lat);
        idle(6);
        check("held_req_acks", 32'(ack_cnt_a - n0), 'd1);
        check("held_req_enables", 32'(en_cnt - e0), 'd1);

        // Port A read data survives a port B write
        access_a(1'b1, 16'h0040, 16'h7777, lat);
        access_a(1'b0, 16'h0040, 16'h0000, lat);
        access_b(1'b1, 16'h0041, 16'h9999, lat);
        idle(2);
        check("hold_data_a", 32'(data_out_a), 'h7777);

        // Randomized concurrent traffic on disjoint address ranges
        fork
            begin
                logic [15:0] a, d;
                bit          rw;
                int          l;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) sync();
                    a  = 16'(16'h0020 + 16'($urandom_range(0, 15)));
                    d  = 16'($urandom);
                    rw = !model_mem.exists(a) || ($urandom_range(0, 1) == 1);
                    access_a(rw, a, d, l);
                    if (l < 3 || l > 7) check("rand_a_lat", 32'(l), 'd3);
                    else                checks++;
                end
            end
            begin
                logic [15:0] a, d;
                bit          rw;
                int          l;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) sync();
                    a  = 16'(16'h0030 + 16'($urandom_range(0, 15)));
                    d  = 16'($urandom);
                    rw = !model_mem.exists(a) || ($urandom_range(0, 1) == 1);
                    access_b(rw, a, d, l);
                    if (l < 3 || l > 7) check("rand_b_lat", 32'(l), 'd3);
                    else                checks++;
                end
            end
        join

        idle(4);
        check("exp_a_drained", 32'(exp_a.size()), 'd0);
        check("exp_b_drained", 32'(exp_b.size()), 'd0);
        check("idle_busy", 32'(busy), 'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
